// File: rtl/scanchain_pkg.sv
// Shared types and defaults for the scan-chain write arbiter: FSM encoding,
// width defaults and the round-robin pointer increment helper.
package scanchain_pkg;

  localparam int ADDR_BITS_DEF    = 12;
  localparam int PAYLOAD_BITS_DEF = 169;
  localparam int NUM_REQ_MAX      = 4;
  localparam int IDX_W            = $clog2(NUM_REQ_MAX);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_t;

  // Next round-robin start position: one past the last grantee, wrapping at num_req.
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] cur, input int num_req);
    logic [IDX_W-1:0] nxt;
    if (int'(cur) >= num_req - 1) begin
      nxt = {IDX_W{1'b0}};
    end else begin
      nxt = cur + {{(IDX_W-1){1'b0}}, 1'b1};
    end
    return nxt;
  endfunction

endpackage

// File: rtl/scanchain_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester at or above the
// pointer, searching upward modulo NUM_REQ.
module rr_picker
  import scanchain_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] i_req_valid,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic               o_any_valid,
  output logic [IDX_W-1:0]   o_winner
);

  // Walk the ring from farthest to nearest so the nearest valid requester wins.
  always_comb begin : p_pick
    int idx;
    idx         = 0;
    o_any_valid = |i_req_valid;
    o_winner    = {IDX_W{1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(i_rr_ptr) + k;
      idx = (idx >= NUM_REQ) ? (idx - NUM_REQ) : idx;
      for (int j = 0; j < NUM_REQ; j++) begin
        o_winner = ((j == idx) && i_req_valid[j]) ? IDX_W'(j) : o_winner;
      end
    end
  end

endmodule

// File: rtl/scanchain_arbiter.sv
// Round-robin arbiter sharing one scanchain_writer among NUM_REQ requesters.
// Optional watchdog enabled with `define SCAN_ARB_TIMEOUT_EN.
module scanchain_arbiter
  import scanchain_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_BITS      = ADDR_BITS_DEF,
  parameter int PAYLOAD_BITS   = PAYLOAD_BITS_DEF,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*ADDR_BITS-1:0]    req_addr,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_payload,
  input  logic [NUM_REQ-1:0]              req_reset,
  output logic                            wr_valid,
  input  logic                            wr_ready,
  output logic [ADDR_BITS-1:0]            wr_addr,
  output logic [PAYLOAD_BITS-1:0]         wr_payload,
  output logic                            wr_reset,
  output logic                            busy,
  output logic [1:0]                      owner,
  output logic                            done,
  output logic                            timeout_err
);

  arb_state_t               r_state;
  arb_state_t               w_state_next;
  logic [IDX_W-1:0]         r_rr_ptr;
  logic [IDX_W-1:0]         r_owner;
  logic                     r_wr_valid;
  logic [ADDR_BITS-1:0]     r_wr_addr;
  logic [PAYLOAD_BITS-1:0]  r_wr_payload;
  logic                     r_wr_reset;
  logic                     r_done;
  logic                     w_any;
  logic [IDX_W-1:0]         w_winner;
  logic                     w_xfer;
  logic                     w_timeout;
  logic [ADDR_BITS-1:0]     w_sel_addr;
  logic [PAYLOAD_BITS-1:0]  w_sel_payload;
  logic                     w_sel_reset;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .i_req_valid (req_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_any_valid (w_any),
    .o_winner    (w_winner)
  );

`ifdef SCAN_ARB_TIMEOUT_EN
  logic [25:0] r_wd_cnt;
  logic        r_timeout_err;

  assign w_timeout   = (r_state != ST_IDLE) && (r_wd_cnt == 26'(TIMEOUT_CYCLES - 1));
  assign timeout_err = r_timeout_err;

  // Watchdog: restarts on each accept, counts every cycle a transaction is owned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wd_cnt      <= 26'd0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= r_timeout_err | w_timeout;
      if (w_xfer) begin
        r_wd_cnt <= 26'd0;
      end else if (r_state != ST_IDLE) begin
        r_wd_cnt <= r_wd_cnt + 26'd1;
      end else begin
        r_wd_cnt <= r_wd_cnt;
      end
    end
  end
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Grant only in IDLE with the writer ready; accept is the winner's valid/ready pair.
  always_comb begin
    w_xfer        = (r_state == ST_IDLE) && wr_ready && w_any;
    req_ready     = {NUM_REQ{1'b0}};
    w_sel_addr    = {ADDR_BITS{1'b0}};
    w_sel_payload = {PAYLOAD_BITS{1'b0}};
    w_sel_reset   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i]  = w_xfer && (w_winner == IDX_W'(i));
      w_sel_addr    = (w_winner == IDX_W'(i)) ? req_addr[i*ADDR_BITS +: ADDR_BITS] : w_sel_addr;
      w_sel_payload = (w_winner == IDX_W'(i)) ? req_payload[i*PAYLOAD_BITS +: PAYLOAD_BITS]
                                              : w_sel_payload;
      w_sel_reset   = (w_winner == IDX_W'(i)) ? req_reset[i] : w_sel_reset;
    end
  end

  // Next-state logic; a watchdog expiry from any owned state abandons the transaction.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        w_state_next = w_xfer ? ST_ISSUE : ST_IDLE;
      end
      ST_ISSUE: begin
        if (w_timeout) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = (r_wr_valid && wr_ready) ? ST_WAIT_BUSY : ST_ISSUE;
        end
      end
      ST_WAIT_BUSY: begin
        if (w_timeout) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = wr_ready ? ST_WAIT_BUSY : ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (w_timeout) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = wr_ready ? ST_IDLE : ST_WAIT_DONE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Writer-side datapath, ownership and round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_valid   <= 1'b0;
      r_wr_addr    <= {ADDR_BITS{1'b0}};
      r_wr_payload <= {PAYLOAD_BITS{1'b0}};
      r_wr_reset   <= 1'b0;
      r_owner      <= {IDX_W{1'b0}};
      r_done       <= 1'b0;
      r_rr_ptr     <= {IDX_W{1'b0}};
    end else begin
      r_done <= 1'b0;
      if (w_timeout) begin
        r_wr_valid <= 1'b0;
        r_rr_ptr   <= rr_next(r_owner, NUM_REQ);
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_xfer) begin
              r_wr_valid   <= 1'b1;
              r_wr_addr    <= w_sel_addr;
              r_wr_payload <= w_sel_payload;
              r_wr_reset   <= w_sel_reset;
              r_owner      <= w_winner;
            end else begin
              r_wr_valid <= 1'b0;
            end
          end
          ST_ISSUE: begin
            r_wr_valid <= !(r_wr_valid && wr_ready);
          end
          ST_WAIT_BUSY: begin
            r_wr_valid <= 1'b0;
          end
          ST_WAIT_DONE: begin
            if (wr_ready) begin
              r_done   <= 1'b1;
              r_rr_ptr <= rr_next(r_owner, NUM_REQ);
            end else begin
              r_done <= 1'b0;
            end
          end
          default: begin
            r_wr_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign wr_valid   = r_wr_valid;
  assign wr_addr    = r_wr_addr;
  assign wr_payload = r_wr_payload;
  assign wr_reset   = r_wr_reset;
  assign done       = r_done;
  assign owner      = 2'(r_owner);
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_scanchain_arbiter.sv
// Self-checking bench for scanchain_arbiter: reset table, directed corner
// sequences and randomized traffic against a transaction-level reference model.
module tb_scanchain_arbiter;

  localparam int N  = 2;
  localparam int AB = 12;
  localparam int PB = 169;
  localparam int TO = 100;

  localparam int WM_NORMAL     = 0;
  localparam int WM_MANUAL     = 1;
  localparam int WM_NEVER_BUSY = 2;
  localparam int WM_NEVER_DONE = 3;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AB-1:0] req_addr;
  logic [N*PB-1:0] req_payload;
  logic [N-1:0]    req_reset;
  logic            wr_valid;
  logic            wr_ready;
  logic [AB-1:0]   wr_addr;
  logic [PB-1:0]   wr_payload;
  logic            wr_reset;
  logic            busy;
  logic [1:0]      owner;
  logic            done;
  logic            timeout_err;

  always #5 clk = ~clk;

  scanchain_arbiter #(
    .NUM_REQ(N), .ADDR_BITS(AB), .PAYLOAD_BITS(PB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_payload(req_payload), .req_reset(req_reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_payload(wr_payload), .wr_reset(wr_reset),
    .busy(busy), .owner(owner), .done(done), .timeout_err(timeout_err)
  );

  typedef struct {
    logic [AB-1:0] addr;
    logic [PB-1:0] pay;
    logic          rst;
  } req_t;

  typedef struct {
    logic [N-1:0] valid;
    logic         wrr;
    logic [N-1:0] exp_ready;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  req_t         rq_q [N][$];
  req_t         rq_cur [N];
  logic [N-1:0] rq_v;
  bit           rnd_gaps = 1'b0;

  int  wm_mode  = WM_MANUAL;
  int  busy_len = 3;
  bit  wm_rand  = 1'b0;
  int  busy_left = 0;
  bit  hs_armed = 1'b0;

  int   m_phase = 0;
  int   m_ptr = 0;
  int   m_owner = 0;
  int   m_cyc = 0;
  bit   m_done_next = 1'b0;
  bit   m_terr = 1'b0;
  req_t m_req;
  int   grant_q[$];
  int   acc_cnt [N];

  task automatic check(input string name, input logic [PB-1:0] act, input logic [PB-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PB-1:0] rand_pay();
    logic [191:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return w[PB-1:0];
  endfunction

  // Spec rule: first valid requester scanning upward from ptr, modulo N.
  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      req_valid[i]              = rq_v[i];
      req_addr[i*AB +: AB]      = rq_cur[i].addr;
      req_payload[i*PB +: PB]   = rq_cur[i].pay;
      req_reset[i]              = rq_cur[i].rst;
    end
  endtask

  task automatic push_req(input int i, input logic [AB-1:0] a, input logic [PB-1:0] p, input logic r);
    req_t t;
    t.addr = a; t.pay = p; t.rst = r;
    rq_q[i].push_back(t);
  endtask

  function automatic bit all_idle();
    bit q_empty = 1'b1;
    for (int i = 0; i < N; i++) if (rq_q[i].size() != 0) q_empty = 1'b0;
    return q_empty && (rq_v == '0) && (m_phase == 0) && !m_done_next;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int c = 0;
    while (!all_idle() && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    check(name, PB'(all_idle()), PB'(1));
  endtask

  // Requesters: hold valid/data until accepted, then present the next queued request.
  initial begin
    logic [N-1:0] took;
    forever begin
      @(negedge clk);
      took = reset_n ? (req_valid & req_ready) : '0;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (took[i]) rq_v[i] = 1'b0;
        if (!rq_v[i] && rq_q[i].size() > 0 && (!rnd_gaps || $urandom_range(0, 2) != 0)) begin
          rq_cur[i] = rq_q[i].pop_front();
          rq_v[i]   = 1'b1;
        end
      end
      pack();
    end
  end

  // Writer model: after taking a write it goes not-ready for a while, then ready again.
  initial begin
    forever begin
      @(posedge clk); #2;
      if (!reset_n || wm_mode == WM_MANUAL) begin
        hs_armed  = 1'b0;
        busy_left = 0;
        if (!reset_n && wm_mode != WM_MANUAL) wr_ready = 1'b1;
      end else begin
        if (hs_armed && wm_mode != WM_NEVER_BUSY) begin
          wr_ready  = 1'b0;
          busy_left = wm_rand ? $urandom_range(1, 4) : busy_len;
        end else if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0 && wm_mode != WM_NEVER_DONE) wr_ready = 1'b1;
        end else if (wm_mode == WM_NORMAL || wm_mode == WM_NEVER_BUSY) begin
          wr_ready = 1'b1;
        end
        hs_armed = wr_valid && wr_ready;
      end
    end
  end

  // Reference model: one owned transaction at a time, checked every cycle.
  initial begin
    logic [N-1:0] exp_rr;
    int w;
    bit timed_out;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_phase = 0; m_ptr = 0; m_owner = 0; m_cyc = 0;
        m_done_next = 1'b0; m_terr = 1'b0;
      end else begin
        exp_rr = '0;
        w = -1;
        if (m_phase == 0 && wr_ready) begin
          w = pick(req_valid, m_ptr);
          if (w >= 0) exp_rr[w] = 1'b1;
        end
        check("req_ready", PB'(req_ready), PB'(exp_rr));
        check("busy", PB'(busy), PB'(m_phase != 0));
        check("wr_valid", PB'(wr_valid), PB'(m_phase == 1));
        check("done", PB'(done), PB'(m_done_next));
        check("timeout_err", PB'(timeout_err), PB'(m_terr));
        if (m_phase != 0) begin
          check("owner", PB'(owner), PB'(m_owner));
          check("wr_addr", PB'(wr_addr), PB'(m_req.addr));
          check("wr_payload", wr_payload, m_req.pay);
          check("wr_reset", PB'(wr_reset), PB'(m_req.rst));
        end
        m_done_next = 1'b0;
        timed_out   = 1'b0;
`ifdef SCAN_ARB_TIMEOUT_EN
        if (m_phase != 0) begin
          m_cyc++;
          if (m_cyc == TO) begin
            timed_out = 1'b1;
            m_phase   = 0;
            m_terr    = 1'b1;
            m_ptr     = (m_owner + 1) % N;
          end
        end
`endif
        if (!timed_out) begin
          if (m_phase == 0 && w >= 0) begin
            m_owner = w; m_req = rq_cur[w]; m_phase = 1; m_cyc = 0;
            grant_q.push_back(w);
            acc_cnt[w]++;
          end else if (m_phase == 1 && wr_ready) begin
            m_phase = 2;
          end else if (m_phase == 2 && !wr_ready) begin
            m_phase = 3;
          end else if (m_phase == 3 && wr_ready) begin
            m_phase = 0; m_done_next = 1'b1; m_ptr = (m_owner + 1) % N;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    req_t saved;
    int   c;
    int   acc1;

    vecs[0] = '{valid: 2'b00, wrr: 1'b1, exp_ready: 2'b00};
    vecs[1] = '{valid: 2'b01, wrr: 1'b1, exp_ready: 2'b01};
    vecs[2] = '{valid: 2'b10, wrr: 1'b1, exp_ready: 2'b10};
    vecs[3] = '{valid: 2'b11, wrr: 1'b1, exp_ready: 2'b01};
    vecs[4] = '{valid: 2'b11, wrr: 1'b0, exp_ready: 2'b00};
    vecs[5] = '{valid: 2'b10, wrr: 1'b0, exp_ready: 2'b00};

    for (int i = 0; i < N; i++) begin
      rq_cur[i].addr = '0; rq_cur[i].pay = '0; rq_cur[i].rst = 1'b0;
      acc_cnt[i] = 0;
    end
    rq_v = '0; pack();
    wr_ready = 1'b1;
    reset_n  = 1'b0;
    #1;
    check("rst_wr_valid", PB'(wr_valid), PB'(0));
    check("rst_busy", PB'(busy), PB'(0));
    check("rst_owner", PB'(owner), PB'(0));
    check("rst_done", PB'(done), PB'(0));
    check("rst_wr_addr", PB'(wr_addr), PB'(0));
    check("rst_wr_payload", wr_payload, PB'(0));
    check("rst_timeout_err", PB'(timeout_err), PB'(0));
    // Arbitration table with pointer at reset value 0 (reset held, nothing accepted).
    for (int v = 0; v < 6; v++) begin
      rq_v = vecs[v].valid; pack();
      wr_ready = vecs[v].wrr;
      #0.5;
      check($sformatf("tbl_req_ready_%0d", v), PB'(req_ready), PB'(vecs[v].exp_ready));
    end
    rq_v = '0; pack();
    wr_ready = 1'b1;
    wm_mode  = WM_NORMAL;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Single request with a 20-cycle writer.
    busy_len = 20;
    push_req(0, 12'h0A5, PB'(1), 1'b0);
    wait_idle("single_idle", 200);
    check("single_acc0", PB'(acc_cnt[0]), PB'(1));
    check("single_owner", PB'(owner), PB'(0));
    check("single_addr", PB'(wr_addr), PB'(12'h0A5));

    // Writer not ready in IDLE: no accept until it becomes ready.
    busy_len = 3;
    @(posedge clk); #1;
    wm_mode = WM_MANUAL; wr_ready = 1'b0;
    push_req(0, 12'h123, rand_pay(), 1'b0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      check("nrdy_req_ready", PB'(req_ready), PB'(2'b00));
    end
    @(posedge clk); #1;
    wr_ready = 1'b1; wm_mode = WM_NORMAL;
    @(negedge clk); #1;
    check("nrdy_accept", PB'(req_ready), PB'(2'b01));
    wait_idle("nrdy_idle", 100);

    // Reset flag propagation: requester 1 then requester 0.
    push_req(1, 12'h03C, PB'(0), 1'b1);
    wait_idle("rstflag1_idle", 100);
    check("rstflag1_wr_reset", PB'(wr_reset), PB'(1));
    push_req(0, 12'h03D, rand_pay(), 1'b0);
    wait_idle("rstflag0_idle", 100);
    check("rstflag0_wr_reset", PB'(wr_reset), PB'(0));

    // Reset during WAIT_DONE, then the same request again.
    busy_len = 20;
    saved.addr = 12'h2AA; saved.pay = rand_pay(); saved.rst = 1'b0;
    rq_q[1].push_back(saved);
    acc1 = acc_cnt[1];
    c = 0;
    while (m_phase != 3 && c < 100) begin
      @(negedge clk); #1; c++;
    end
    check("midrst_reach_wait_done", PB'(m_phase == 3), PB'(1));
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("midrst_wr_valid", PB'(wr_valid), PB'(0));
    check("midrst_busy", PB'(busy), PB'(0));
    check("midrst_owner", PB'(owner), PB'(0));
    rq_v = '0; pack();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    rq_q[1].push_back(saved);
    wait_idle("midrst_idle", 200);
    check("midrst_reaccept", PB'(acc_cnt[1] - acc1), PB'(2));
    check("midrst_owner_after", PB'(owner), PB'(1));

    // Contention: both requesters continuously valid, three writes each.
    busy_len = 2;
    @(negedge clk);
    grant_q.delete();
    for (int k = 0; k < 3; k++) begin
      push_req(0, AB'($urandom), rand_pay(), 1'b0);
      push_req(1, AB'($urandom), rand_pay(), 1'b0);
    end
    wait_idle("cont_idle", 300);
    check("cont_count", PB'(grant_q.size()), PB'(6));
    for (int k = 0; k < grant_q.size(); k++) begin
      check($sformatf("cont_grant_%0d", k), PB'(grant_q[k]), PB'(k % 2));
    end

    // Writer accepts but never goes busy: legal hang (or watchdog expiry).
    wm_mode = WM_NEVER_BUSY;
    push_req(0, 12'h111, rand_pay(), 1'b0);
    repeat (30) @(negedge clk);
    #1;
    check("hang_busy", PB'(busy), PB'(1));
`ifdef SCAN_ARB_TIMEOUT_EN
    wait_idle("hang_timeout_idle", 300);
    check("hang_timeout_err", PB'(timeout_err), PB'(1));
    wm_mode = WM_NORMAL;
    // Writer goes busy and never returns: watchdog, no done, then normal service.
    wm_mode = WM_NEVER_DONE;
    push_req(1, 12'h222, rand_pay(), 1'b0);
    wait_idle("to_idle", 300);
    check("to_busy", PB'(busy), PB'(0));
    wm_mode = WM_NORMAL;
    acc1 = acc_cnt[0];
    push_req(0, 12'h333, rand_pay(), 1'b0);
    wait_idle("to_next_idle", 100);
    check("to_next_served", PB'(acc_cnt[0] - acc1), PB'(1));
`else
    check("hang_timeout_err", PB'(timeout_err), PB'(0));
    @(posedge clk); #1;
    reset_n = 1'b0;
    wm_mode = WM_NORMAL;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
`endif

    // Randomized traffic with random writer busy times and request gaps.
    wm_rand  = 1'b1;
    rnd_gaps = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) != 0) push_req(i, AB'($urandom), rand_pay(), 1'($urandom));
      end
    end
    wait_idle("rand_idle", 5000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scanchain_arbiter.md
Name: scanchain_arbiter

Overview:
- Shares one scanchain_writer between NUM_REQ write requesters: requester 0 is the UART client, requester 1 is an on-FPGA init/boot sequencer.
- Round-robin grant. Each accepted request is owned end-to-end: accept, issue to the writer, writer busy, writer ready again.
- Sits between the requesters and scanchain_writer in the A7 top. Exports status for the LEDs.

Parameters:
- NUM_REQ, 2, number of requesters (2..4)
- ADDR_BITS, 12, scan write address width
- PAYLOAD_BITS, 169, scan payload width
- TIMEOUT_CYCLES, 50_000_000, watchdog limit (used only with the optional feature)

Ports:
- clk  in  1  FPGA clock
- reset_n  in  1  async active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept
- req_addr  in  NUM_REQ*ADDR_BITS  flattened; requester i at [i*ADDR_BITS +: ADDR_BITS]
- req_payload  in  NUM_REQ*PAYLOAD_BITS  flattened, same slicing rule
- req_reset  in  NUM_REQ  per-requester scan-reset flag
- wr_valid  out  1  to writer write_valid
- wr_ready  in  1  from writer write_ready
- wr_addr  out  ADDR_BITS  latched address
- wr_payload  out  PAYLOAD_BITS  latched payload
- wr_reset  out  1  latched reset flag
- busy  out  1  high whenever state != IDLE
- owner  out  2  index of the current or last grantee
- done  out  1  one-cycle pulse when a transaction completes
- timeout_err  out  1  sticky watchdog error; constant 0 without the feature

Behaviour:
- Reset is asynchronous and active-low. One clock domain (clk).
- Reset values: state=IDLE; wr_valid=0; wr_addr=0; wr_payload=0; wr_reset=0; owner=0; done=0; timeout_err=0; rr_ptr=0.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Winner = first i with req_valid[i] set, searching from rr_ptr upward modulo NUM_REQ.
  - req_ready[winner] is combinational: (state==IDLE) && wr_ready && req_valid[winner]. All other req_ready bits are 0.
  - On transfer (req_valid & req_ready), latch addr, payload and reset flag from that requester; owner<=winner; go to ISSUE.
- ISSUE:
  - wr_valid=1, data held stable.
  - On wr_valid && wr_ready: wr_valid<=0, go to WAIT_BUSY.
- WAIT_BUSY: wait for wr_ready==0 (the writer has started), then go to WAIT_DONE.
- WAIT_DONE: on wr_ready==1, go to IDLE; done=1 for that cycle; rr_ptr<=owner+1 modulo NUM_REQ.
- Latency: request accepted to wr_valid = 1 cycle. Done to the next possible accept = 1 cycle.
- req_ready is 0 in every state except IDLE. New requests wait; none are dropped. A requester must hold valid and data until it sees ready.
- Simultaneous requests: rr_ptr decides. A requester that is granted gets lowest priority for the next arbitration.
- Requester deasserts valid in the same cycle it would be accepted: no transfer, stay in IDLE.
- Writer not ready while in IDLE: no accept, regardless of requests.
- wr_ready held high forever after the handshake (writer never goes busy): stuck in WAIT_BUSY. This is a legal hang without the feature.
- Reset mid-transaction: immediate return to IDLE and reset values. Any latched request is discarded. The requester must re-request.
- rr_ptr arithmetic wraps: NUM_REQ-1 -> 0.

Optional Feature:
- Macro: SCAN_ARB_TIMEOUT_EN.
- With the macro:
  - A 26-bit cycle counter clears on entry to ISSUE and counts in ISSUE, WAIT_BUSY and WAIT_DONE.
  - On reaching TIMEOUT_CYCLES: timeout_err<=1 (sticky until reset), wr_valid<=0, state<=IDLE, rr_ptr advances, no done pulse.
- Without the macro: no counter; timeout_err tied to 0.

Decomposition:
- Shared package scanchain_pkg holds:
  - ADDR_BITS and PAYLOAD_BITS defaults
  - FSM state encoding: IDLE=2'd0, ISSUE=2'd1, WAIT_BUSY=2'd2, WAIT_DONE=2'd3
  - NUM_REQ_MAX=4
- One sub-module: rr_picker. It is combinational. It takes (req_valid, rr_ptr) and returns (any_valid, winner). The arbiter instantiates it once.

Test Plan:
- Single request: req_valid=01, addr0=12'h0A5, payload0=169'h1. Writer model goes busy for 20 cycles. Expect one req_ready[0] pulse; wr_valid the next cycle with addr 0A5; done exactly 1 cycle after wr_ready rises; owner=0.
- Contention: req_valid=11 held, with 3 transactions per requester. Expect grants 0,1,0,1,0,1 and no two consecutive grants to the same requester.
- Writer not ready: wr_ready=0 in IDLE with req_valid=01. Expect req_ready=00 until wr_ready=1, then accept in that cycle.
- Reset mid-op: assert reset_n=0 during WAIT_DONE. Expect wr_valid=0, busy=0 and owner=0 asynchronously. After release, the same request is re-accepted and completes.
- Timeout (macro on, TIMEOUT_CYCLES=100): writer never returns ready. Expect timeout_err=1 at cycle 100 after ISSUE entry, busy=0 and no done pulse. The next request is still served.
- wr_reset propagation: req_reset[1]=1 with payload1=0. Expect wr_reset=1 for the whole transaction; wr_reset=0 on the next transaction from requester 0.
